// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter with wrap limit, sync load and 7-seg scan driver
// Ports: clk, reset (async active-high); enable, up_down, load, load_val (packed BCD) in;
//        count_out (packed BCD), carry (wrap pulse), zero, seg7_sel, seg7_out (abcdefg),
//        dpt_out (0), led_com (1) out.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits above digit 0.
module bcd_updown_counter #(
    parameter int DIGITS = 3,
    parameter logic [4*DIGITS-1:0] LIMIT = 12'h321,
    parameter int TICK_DIV = 21,
    parameter int SCAN_DIV = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  carry,
    output logic                  zero,
    output logic [2:0]            seg7_sel,
    output logic [6:0]            seg7_out,
    output logic                  dpt_out,
    output logic                  led_com
);
    localparam int W = 4*DIGITS;
    logic [TICK_DIV-1:0] r_tick;
    logic [SCAN_DIV-1:0] r_scan;
    logic [W-1:0]        r_count;
    logic                r_carry;
    logic [2:0]          r_sel;
    logic                w_tick_stb, w_scan_stb, w_at_limit, w_at_zero, w_load_bad, w_blank;
    logic [W-1:0]        w_inc, w_dec;
    logic [3:0]          w_digit;
    assign w_tick_stb = &r_tick;
    assign w_scan_stb = &r_scan;
    assign w_at_limit = r_count == LIMIT;
    assign w_at_zero  = r_count == '0;
    // Ripple BCD increment/decrement; with valid digits a binary compare equals the BCD compare.
    always_comb begin
        logic c, b;
        c = 1'b1;
        b = 1'b1;
        w_inc = r_count;
        w_dec = r_count;
        w_load_bad = load_val > LIMIT;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                w_inc[4*i +: 4] = (r_count[4*i +: 4] == 4'd9) ? 4'd0 : r_count[4*i +: 4] + 4'd1;
                c = r_count[4*i +: 4] == 4'd9;
            end
            if (b) begin
                w_dec[4*i +: 4] = (r_count[4*i +: 4] == 4'd0) ? 4'd9 : r_count[4*i +: 4] - 4'd1;
                b = r_count[4*i +: 4] == 4'd0;
            end
            w_load_bad = w_load_bad | (load_val[4*i +: 4] > 4'd9);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick  <= '0;
            r_scan  <= '0;
            r_count <= '0;
            r_carry <= 1'b0;
            r_sel   <= 3'd5;
        end else begin
            r_tick  <= r_tick + TICK_DIV'(1);
            r_scan  <= r_scan + SCAN_DIV'(1);
            r_carry <= 1'b0;
            if (load)
                r_count <= w_load_bad ? LIMIT : load_val;
            else if (w_tick_stb && enable) begin
                if (up_down) begin
                    r_count <= w_at_limit ? '0 : w_inc;
                    r_carry <= w_at_limit;
                end else begin
                    r_count <= w_at_zero ? LIMIT : w_dec;
                    r_carry <= w_at_zero;
                end
            end
            if (w_scan_stb)
                r_sel <= (r_sel == 3'(6 - DIGITS)) ? 3'd5 : r_sel - 3'd1;
        end
    end
    // Position 5 shows digit 0, position 4 digit 1, and so on.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic hz;
        hz = 1'b1;
`endif
        w_digit = 4'hF;
        w_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (3'(5 - i) == r_sel) w_digit = r_count[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top digit: a digit blanks while it and everything above it is zero.
        for (int i = DIGITS - 1; i > 0; i--) begin
            hz = hz && (r_count[4*i +: 4] == 4'd0);
            if (3'(5 - i) == r_sel) w_blank = hz;
        end
`endif
    end
    always_comb begin
        case (w_blank ? 4'hF : w_digit)
            4'd0:    seg7_out = 7'b1111110;
            4'd1:    seg7_out = 7'b0110000;
            4'd2:    seg7_out = 7'b1101101;
            4'd3:    seg7_out = 7'b1111001;
            4'd4:    seg7_out = 7'b0110011;
            4'd5:    seg7_out = 7'b1011011;
            4'd6:    seg7_out = 7'b1011111;
            4'd7:    seg7_out = 7'b1110000;
            4'd8:    seg7_out = 7'b1111111;
            4'd9:    seg7_out = 7'b1111011;
            default: seg7_out = 7'b0000000;
        endcase
    end
    assign count_out = r_count;
    assign carry     = r_carry;
    assign zero      = w_at_zero;
    assign seg7_sel  = r_sel;
    assign dpt_out   = 1'b0;
    assign led_com   = 1'b1;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed bench with a decimal-arithmetic reference model checked every cycle
module tb_bcd_updown_counter;
    localparam int DIGITS = 3;
    localparam int W = 4*DIGITS;
    localparam int LIM = 321;
    localparam int TICK_DIV = 2;
    localparam int SCAN_DIV = 1;
    logic clk = 1'b0, reset = 1'b0, enable = 1'b0, up_down = 1'b1, load = 1'b0;
    logic [W-1:0] load_val = '0, count_out;
    logic carry, zero, dpt_out, led_com;
    logic [2:0] seg7_sel;
    logic [6:0] seg7_out;
    int vectors = 0, miscompares = 0;
    bit chk_on = 1'b0;
    int m_count, m_tick, m_scan, m_sel;
    bit m_carry;
    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    bcd_updown_counter #(.DIGITS(DIGITS), .LIMIT(12'h321), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
        .load_val(load_val), .count_out(count_out), .carry(carry), .zero(zero),
        .seg7_sel(seg7_sel), .seg7_out(seg7_out), .dpt_out(dpt_out), .led_com(led_com));
    always #5 clk = ~clk;
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
    function automatic int clamp_load(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (v[4*i +: 4] > 4'd9) return LIM;
            r = r * 10 + int'(v[4*i +: 4]);
        end
        return (r > LIM) ? LIM : r;
    endfunction
    function automatic logic [6:0] exp_seg(input int cnt, input int sel);
        int idx, p;
        idx = 5 - sel;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && cnt / p == 0) return 7'b0000000;
`endif
        return seg_tab[(cnt / p) % 10];
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count <= 0; m_tick <= 0; m_scan <= 0; m_sel <= 5; m_carry <= 1'b0;
        end else begin
            m_carry <= 1'b0;
            if (load) m_count <= clamp_load(load_val);
            else if (enable && m_tick == (1 << TICK_DIV) - 1) begin
                if (up_down) begin
                    m_count <= (m_count == LIM) ? 0 : m_count + 1;
                    m_carry <= m_count == LIM;
                end else begin
                    m_count <= (m_count == 0) ? LIM : m_count - 1;
                    m_carry <= m_count == 0;
                end
            end
            m_tick <= (m_tick + 1) % (1 << TICK_DIV);
            m_scan <= (m_scan + 1) % (1 << SCAN_DIV);
            if (m_scan == (1 << SCAN_DIV) - 1) m_sel <= (m_sel == 6 - DIGITS) ? 5 : m_sel - 1;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (chk_on) begin
        chk("count_out", 32'(count_out), 32'(to_bcd(m_count)));
        chk("carry", 32'(carry), 32'(m_carry));
        chk("zero", 32'(zero), 32'(m_count == 0));
        chk("seg7_sel", 32'(seg7_sel), 32'(m_sel));
        chk("seg7_out", 32'(seg7_out), 32'(exp_seg(m_count, m_sel)));
        chk("dpt_led", {30'd0, dpt_out, led_com}, 32'b01);
    end
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask
    task automatic strobes(input int n);
        for (int s = 0; s < n; s++) begin
            int k;
            k = 0;
            do begin cyc(); k++; end while (m_tick != 0 && k < 10);
            if (k >= 10) chk("strobe_timeout", 32'(k), 32'd0);
        end
    endtask
    task automatic wait_sel(input logic [2:0] v);
        int k;
        k = 0;
        while (seg7_sel !== v && k < 8) begin cyc(); k++; end
        chk("wait_sel", 32'(seg7_sel), 32'(v));
    endtask
    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        cyc();
        load = 1'b0;
    endtask
    initial begin
        #1 reset = 1'b1;
        chk_on = 1'b1;
        cyc(); cyc();
        chk("rst_count", 32'(count_out), 32'h000);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_sel", 32'(seg7_sel), 32'd5);
        chk("rst_dpt", 32'(dpt_out), 32'd0);
        chk("rst_com", 32'(led_com), 32'd1);
        // full up-count cycle from reset
        reset = 1'b0; enable = 1'b1; up_down = 1'b1;
        strobes(321);
        chk("up_321", 32'(count_out), 32'h321);
        chk("up_no_carry", 32'(carry), 32'd0);
        strobes(1);
        chk("up_wrap", 32'(count_out), 32'h000);
        chk("up_wrap_carry", 32'(carry), 32'd1);
        cyc();
        chk("carry_one_cycle", 32'(carry), 32'd0);
        // down count from reset
        reset = 1'b1; cyc(); reset = 1'b0; up_down = 1'b0;
        strobes(1);
        chk("dn_wrap", 32'(count_out), 32'h321);
        chk("dn_wrap_carry", 32'(carry), 32'd1);
        strobes(1);
        chk("dn_320", 32'(count_out), 32'h320);
        do_load(12'h100);
        chk("load_100", 32'(count_out), 32'h100);
        strobes(1);
        chk("dn_borrow", 32'(count_out), 32'h099);
        // out-of-range loads clamp to the limit
        enable = 1'b0;
        do_load(12'h3A0);
        chk("load_3A0", 32'(count_out), 32'h321);
        chk("load_3A0_carry", 32'(carry), 32'd0);
        do_load(12'h400);
        chk("load_400", 32'(count_out), 32'h321);
        chk("load_400_carry", 32'(carry), 32'd0);
        // load on a strobe cycle wins
        enable = 1'b1; up_down = 1'b1;
        for (int k = 0; k < 8 && m_tick != 3; k++) cyc();
        do_load(12'h045);
        chk("load_on_strobe", 32'(count_out), 32'h045);
        chk("load_on_strobe_carry", 32'(carry), 32'd0);
        enable = 1'b0;
        strobes(3);
        chk("pause_hold", 32'(count_out), 32'h045);
        enable = 1'b1;
        strobes(1);
        chk("resume", 32'(count_out), 32'h046);
        // scan sequence and decode
        enable = 1'b0;
        do_load(12'h007);
        wait_sel(3'd5);
        wait_sel(3'd4);
`ifdef LEADING_ZERO_BLANK_EN
        chk("seg_pos4_007", 32'(seg7_out), 32'h00);
        wait_sel(3'd3);
        chk("seg_pos3_007", 32'(seg7_out), 32'h00);
`else
        chk("seg_pos4_007", 32'(seg7_out), 32'(7'b1111110));
        wait_sel(3'd3);
        chk("seg_pos3_007", 32'(seg7_out), 32'(7'b1111110));
`endif
        wait_sel(3'd5);
        chk("seg_pos5_007", 32'(seg7_out), 32'(7'b1110000));
        do_load(12'h210);
        wait_sel(3'd5);
        chk("seg_pos5_210", 32'(seg7_out), 32'(7'b1111110));
        wait_sel(3'd4);
        chk("seg_pos4_210", 32'(seg7_out), 32'(7'b0110000));
        wait_sel(3'd3);
        chk("seg_pos3_210", 32'(seg7_out), 32'(7'b1101101));
        // asynchronous reset between clock edges
        enable = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_count", 32'(count_out), 32'h000);
        chk("async_zero", 32'(zero), 32'd1);
        chk("async_carry", 32'(carry), 32'd0);
        chk("async_sel", 32'(seg7_sel), 32'd5);
        cyc();
        reset = 1'b0;
        strobes(2);
        chk("post_reset_count", 32'(count_out), 32'h002);
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
